// File: rtl/my_button_cmd_unit_pkg.sv
// Shared command codes and entry sizing for the button command front-end.
// Codes feed my_associative_buffer control decoding.
package my_button_cmd_unit_pkg;

    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_INCR = 3'd1,
        CMD_LOAD = 3'd2,
        CMD_CLR  = 3'd3
    } cmd_code_e;

    localparam int DEF_BUTTON_NUMBER = 3;
    localparam int DEF_CMD_WIDTH     = 3;
    localparam int DEF_KEY_WIDTH     = 4;
    localparam int DEF_DATA_WIDTH    = 2;

    function automatic int entry_width(input int cw, input int kw, input int dw);
        return cw + kw + dw;
    endfunction

endpackage

// File: rtl/my_button_cmd_unit_if.sv
// Command stream from the button front-end to its consumer.
// valid/ready handshake with code, key and data payload.
interface my_button_cmd_unit_if #(
    parameter int CMD_WIDTH  = 3,
    parameter int KEY_WIDTH  = 4,
    parameter int DATA_WIDTH = 2
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [CMD_WIDTH-1:0]  cmd_code;
    logic [KEY_WIDTH-1:0]  cmd_key;
    logic [DATA_WIDTH-1:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_code,
        output cmd_key,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_code,
        input  cmd_key,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/my_cmd_fifo.sv
// First-word-fall-through FIFO with full/empty/level.
// A push into a full FIFO is accepted only when a pop frees a slot that cycle.
module my_cmd_fifo #(
    parameter int WIDTH      = 9,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [WIDTH-1:0]    din,
    input  logic                pop,
    output logic [WIDTH-1:0]    dout,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_LOG2:0] level
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    // Output forced to zero while empty so stale storage never leaks out
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/my_button_cmd_unit.sv
// Buttons -> sync/debounce -> edge -> priority -> command FIFO.
// MY_BUTTON_CMD_UNIT_AUTOREPEAT_EN adds periodic repeat events while held.
module my_button_cmd_unit
    import my_button_cmd_unit_pkg::*;
#(
    parameter int BUTTON_NUMBER   = DEF_BUTTON_NUMBER,
    parameter int CMD_WIDTH       = DEF_CMD_WIDTH,
    parameter int KEY_WIDTH       = DEF_KEY_WIDTH,
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int DEBOUNCE_LOG2   = 4,
    parameter int FIFO_DEPTH_LOG2 = 2,
    parameter int REPEAT_LOG2     = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [BUTTON_NUMBER-1:0]   buttons,
    input  logic [KEY_WIDTH-1:0]       key_input,
    input  logic [DATA_WIDTH-1:0]      data_input,
    my_button_cmd_unit_if.master       cmd,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_level,
    output logic                       overflow,
    input  logic                       clr_overflow
);
    localparam int EW = entry_width(CMD_WIDTH, KEY_WIDTH, DATA_WIDTH);

    if ((1 << CMD_WIDTH) <= BUTTON_NUMBER || REPEAT_LOG2 < 1) begin : g_cfg_err
        $error("my_button_cmd_unit: invalid parameter set");
    end

    logic [BUTTON_NUMBER-1:0] sync1;
    logic [BUTTON_NUMBER-1:0] sync2;
    logic [BUTTON_NUMBER-1:0] stable;
    logic [BUTTON_NUMBER-1:0] stable_d;
    logic [BUTTON_NUMBER-1:0] flip;
    logic [BUTTON_NUMBER-1:0] rise;
    logic [BUTTON_NUMBER-1:0] rpt;
    logic [BUTTON_NUMBER-1:0] evt;
    logic [CMD_WIDTH-1:0]     code;
    logic [CMD_WIDTH-1:0]     ev_code;
    logic                     ev_vld;
    logic [EW-1:0]            fifo_din;
    logic [EW-1:0]            fifo_dout;
    logic                     full;
    logic                     empty;
    logic                     pop;
    logic                     drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
        end else begin
            sync1    <= buttons;
            sync2    <= sync1;
            stable   <= stable ^ flip;
            stable_d <= stable;
        end
    end

    for (genvar i = 0; i < BUTTON_NUMBER; i++) begin : g_btn
        logic [DEBOUNCE_LOG2-1:0] cnt;

        // Flip once the disagreement has lasted the full window
        assign flip[i] = (sync2[i] != stable[i]) && (cnt == '1);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
            end else if (sync2[i] == stable[i] || flip[i]) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

`ifdef MY_BUTTON_CMD_UNIT_AUTOREPEAT_EN
        logic [REPEAT_LOG2-1:0] rcnt;

        // Counts held cycles after the rise cycle; fires each full period
        assign rpt[i] = stable[i] & stable_d[i] & (rcnt == '1);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rcnt <= '0;
            end else if (stable[i] & stable_d[i]) begin
                rcnt <= rcnt + 1'b1;
            end else begin
                rcnt <= '0;
            end
        end
`else
        assign rpt[i] = 1'b0;
`endif
    end

    assign rise = stable & ~stable_d;
    assign evt  = rise | rpt;

    always_comb begin
        code = CMD_WIDTH'(CMD_NOP);
        for (int i = 0; i < BUTTON_NUMBER; i++) begin
            if (evt[i]) code = CMD_WIDTH'(i + 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ev_vld  <= 1'b0;
            ev_code <= '0;
        end else begin
            ev_vld  <= |evt;
            ev_code <= code;
        end
    end

    assign fifo_din = {ev_code, key_input, data_input};
    assign pop      = ~empty & cmd.cmd_ready;
    assign drop     = ev_vld & full & ~pop;

    my_cmd_fifo #(
        .WIDTH      (EW),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ev_vld),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    assign cmd.cmd_valid = ~empty;
    assign {cmd.cmd_code, cmd.cmd_key, cmd.cmd_data} = fifo_dout;

    // A drop in the same cycle as a clear leaves the flag set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_my_button_cmd_unit.sv
// Self-checking bench for my_button_cmd_unit with a queue-based reference model.
// Autorepeat scenario runs only when MY_BUTTON_CMD_UNIT_AUTOREPEAT_EN is defined.
module tb_my_button_cmd_unit;
    localparam int BN    = 3;
    localparam int CW    = 3;
    localparam int KW    = 4;
    localparam int DW    = 2;
    localparam int DB    = 2;
    localparam int FDL   = 2;
    localparam int RL    = 3;
    localparam int WIN   = 1 << DB;
    localparam int DEPTH = 1 << FDL;
    localparam int GAP   = 14;

    typedef struct packed {
        logic [CW-1:0] code;
        logic [KW-1:0] key;
        logic [DW-1:0] data;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [BN-1:0] buttons = '0;
    logic [KW-1:0] key_input = '0;
    logic [DW-1:0] data_input = '0;
    logic          clr_overflow = 1'b0;
    logic [FDL:0]  fifo_level;
    logic          overflow;

    my_button_cmd_unit_if #(.CMD_WIDTH(CW), .KEY_WIDTH(KW), .DATA_WIDTH(DW)) cmd_if();

    my_button_cmd_unit #(
        .BUTTON_NUMBER   (BN),
        .CMD_WIDTH       (CW),
        .KEY_WIDTH       (KW),
        .DATA_WIDTH      (DW),
        .DEBOUNCE_LOG2   (DB),
        .FIFO_DEPTH_LOG2 (FDL),
        .REPEAT_LOG2     (RL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .buttons      (buttons),
        .key_input    (key_input),
        .data_input   (data_input),
        .cmd          (cmd_if),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    ent_t exp_q[$];
    ent_t obs_q[$];
    int   obs_t[$];
    logic exp_ovf;

    always @(posedge clk) cyc++;

    // Record every completed transfer, sampled mid-cycle
    always @(negedge clk) begin
        #2;
        if (!rst && cmd_if.cmd_valid && cmd_if.cmd_ready) begin
            obs_q.push_back(ent_t'{code: cmd_if.cmd_code,
                                   key: cmd_if.cmd_key,
                                   data: cmd_if.cmd_data});
            obs_t.push_back(cyc);
        end
    end

    // Highest pressed index + 1 == floor(log2(mask)) + 1
    function automatic logic [CW-1:0] top_code(input logic [BN-1:0] m);
        return CW'($clog2(int'(m) + 1));
    endfunction

    task automatic model_press(input logic [BN-1:0] m, input int len,
                               input logic [KW-1:0] k, input logic [DW-1:0] d);
        if (m != '0 && len >= WIN) begin
            if (!cmd_if.cmd_ready && exp_q.size() >= DEPTH) exp_ovf = 1'b1;
            else exp_q.push_back(ent_t'{code: top_code(m), key: k, data: d});
        end
    endtask

    task automatic press(input logic [BN-1:0] m, input int len,
                         input logic [KW-1:0] k, input logic [DW-1:0] d);
        @(negedge clk);
        buttons = m;
        key_input = k;
        data_input = d;
        repeat (len) @(negedge clk);
        buttons = '0;
        repeat (GAP) @(negedge clk);
        model_press(m, len, k, d);
    endtask

    task automatic clear_model();
        exp_q.delete();
        obs_q.delete();
        obs_t.delete();
        exp_ovf = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_if.cmd_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (cmd_if.cmd_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_valid got %b want 0", cmd_if.cmd_valid);
        end
        n_cmp++;
        if (fifo_level !== '0) begin
            n_err++; $display("FAIL reset_level got %0d want 0", fifo_level);
        end
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_err++; $display("FAIL reset_overflow got %b want 0", overflow);
        end
        n_cmp++;
        if ({cmd_if.cmd_code, cmd_if.cmd_key, cmd_if.cmd_data} !== '0) begin
            n_err++;
            $display("FAIL reset_payload got %h/%h/%h want 0/0/0",
                     cmd_if.cmd_code, cmd_if.cmd_key, cmd_if.cmd_data);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (cmd_if.cmd_valid !== 1'b0 || fifo_level !== '0) begin
            n_err++;
            $display("FAIL idle_after_reset got valid=%b level=%0d want 0/0",
                     cmd_if.cmd_valid, fifo_level);
        end
    endtask

    task automatic test_latency();
        clear_model();
        @(negedge clk);
        buttons = 3'b001;
        key_input = 4'd5;
        data_input = 2'd2;
        for (int k = 0; k <= 3 + WIN; k++) begin
            @(posedge clk);
            #1;
            if (k == 4) buttons = '0;
            if (k == 2 + WIN) begin
                n_cmp++;
                if (cmd_if.cmd_valid !== 1'b0) begin
                    n_err++; $display("FAIL latency_early got valid=%b want 0", cmd_if.cmd_valid);
                end
            end
            if (k == 3 + WIN) begin
                n_cmp++;
                if (cmd_if.cmd_valid !== 1'b1 ||
                    {cmd_if.cmd_code, cmd_if.cmd_key, cmd_if.cmd_data} !== {3'd1, 4'd5, 2'd2}) begin
                    n_err++;
                    $display("FAIL latency_entry got v=%b %h/%h/%h want 1 1/5/2",
                             cmd_if.cmd_valid, cmd_if.cmd_code, cmd_if.cmd_key, cmd_if.cmd_data);
                end
            end
        end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != 1) begin
            n_err++; $display("FAIL single_press_count got %0d want 1", obs_q.size());
        end
    endtask

    task automatic test_debounce();
        clear_model();
        press(3'b010, 2, 4'd9, 2'd1);
        press(3'b010, 4, 4'd3, 2'd3);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL debounce_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL debounce_entry%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_priority();
        clear_model();
        press(3'b101, 5, 4'd7, 2'd0);
        press(3'b011, 5, 4'd1, 2'd1);
        press(3'b111, 6, 4'd15, 2'd3);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL priority_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL priority_entry%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        clear_model();
        for (int n = 0; n < 14; n++) begin
            press(BN'($urandom_range(1, 7)), $urandom_range(1, 7),
                  KW'($urandom), DW'($urandom));
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL random_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL random_entry%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_overflow();
        clear_model();
        cmd_if.cmd_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            press(BN'($urandom_range(1, 7)), 5, KW'($urandom), DW'($urandom));
        end
        n_cmp++;
        if (fifo_level !== (FDL+1)'(exp_q.size()) || overflow !== exp_ovf) begin
            n_err++;
            $display("FAIL overflow_state got level=%0d ovf=%b want %0d/%b",
                     fifo_level, overflow, exp_q.size(), exp_ovf);
        end
        cmd_if.cmd_ready = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != exp_q.size() || fifo_level !== '0) begin
            n_err++;
            $display("FAIL overflow_drain got n=%0d level=%0d want %0d/0",
                     obs_q.size(), fifo_level, exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL overflow_entry%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_err++; $display("FAIL clr_overflow got %b want 0", overflow);
        end
    endtask

    task automatic test_full_push_pop();
        clear_model();
        cmd_if.cmd_ready = 1'b0;
        for (int n = 0; n < DEPTH; n++) begin
            press(BN'($urandom_range(1, 7)), 5, KW'($urandom), DW'($urandom));
        end
        @(negedge clk);
        buttons = 3'b010;
        key_input = 4'd12;
        data_input = 2'd1;
        repeat (3 + WIN) @(posedge clk);
        @(negedge clk);
        cmd_if.cmd_ready = 1'b1;
        buttons = '0;
        @(posedge clk);
        #1;
        exp_q.push_back(ent_t'{code: 3'd2, key: 4'd12, data: 2'd1});
        n_cmp++;
        if (fifo_level !== (FDL+1)'(DEPTH) || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL full_push_pop got level=%0d ovf=%b want %0d/0",
                     fifo_level, overflow, DEPTH);
        end
        @(negedge clk);
        cmd_if.cmd_ready = 1'b0;
        repeat (GAP) @(negedge clk);
        cmd_if.cmd_ready = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL full_pp_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL full_pp_entry%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        clear_model();
        cmd_if.cmd_ready = 1'b0;
        press(3'b001, 5, 4'd2, 2'd2);
        press(3'b100, 5, 4'd4, 2'd0);
        n_cmp++;
        if (fifo_level !== (FDL+1)'(exp_q.size())) begin
            n_err++; $display("FAIL pre_reset_level got %0d want %0d", fifo_level, exp_q.size());
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (cmd_if.cmd_valid !== 1'b0 || fifo_level !== '0) begin
            n_err++;
            $display("FAIL async_reset got valid=%b level=%0d want 0/0",
                     cmd_if.cmd_valid, fifo_level);
        end
        @(negedge clk);
        rst = 1'b0;
        cmd_if.cmd_ready = 1'b1;
        repeat (6) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_err++; $display("FAIL reset_discard got %0d entries want 0", obs_q.size());
        end
    endtask

`ifdef MY_BUTTON_CMD_UNIT_AUTOREPEAT_EN
    task automatic test_autorepeat();
        clear_model();
        cmd_if.cmd_ready = 1'b1;
        @(negedge clk);
        buttons = 3'b001;
        key_input = 4'd6;
        data_input = 2'd1;
        repeat (40) @(negedge clk);
        buttons = '0;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (obs_q.size() < 3) begin
            n_err++; $display("FAIL repeat_count got %0d want >=3", obs_q.size());
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].code !== 3'd1) begin
                n_err++; $display("FAIL repeat_code%0d got %0d want 1", i, obs_q[i].code);
            end
            if (i > 0) begin
                n_cmp++;
                if (obs_t[i] - obs_t[i-1] != (1 << RL)) begin
                    n_err++;
                    $display("FAIL repeat_period%0d got %0d want %0d",
                             i, obs_t[i] - obs_t[i-1], 1 << RL);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_debounce();
        test_priority();
        test_random();
        test_overflow();
        test_full_push_pop();
        test_async_reset();
`ifdef MY_BUTTON_CMD_UNIT_AUTOREPEAT_EN
        test_autorepeat();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
